// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Two-port round-robin controller for a word-wide data memory.
//             Full-word stores write directly. Partial byte-strobed stores use
//             a read-modify-write sequence. Registered responses go back to
//             the port that was granted.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // port 0 (core LSU)
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  input  logic [3:0]    p0_req_wstrb,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  // port 1 (DMA / debug)
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  input  logic [3:0]    p1_req_wstrb,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]    r_state;
  logic          r_last_grant;
  logic [DW-1:0] r_merge;
  logic [AW-1:0] r_rmw_addr;
  logic          r_rmw_port;
  logic          r_p0_rsp_valid;
  logic          r_p1_rsp_valid;
  logic [DW-1:0] r_p0_rsp_rdata;
  logic [DW-1:0] r_p1_rsp_rdata;

  logic          w_idle;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any_gnt;
  logic          w_sel;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [3:0]    w_wstrb;
  logic          w_full;
  logic          w_partial;
  logic [DW-1:0] w_merge;

  // Round-robin grant: a tie goes to the port that was not granted last.
  always_comb begin
    w_idle    = rst_n && (r_state == IDLE);
    w_gnt0    = w_idle && p0_req_valid && (!p1_req_valid || r_last_grant);
    w_gnt1    = w_idle && p1_req_valid && (!p0_req_valid || !r_last_grant);
    w_any_gnt = w_gnt0 || w_gnt1;
    w_sel     = w_gnt1;
  end

  // Multiplex the granted request's fields and classify the store type.
  always_comb begin
    w_we      = w_sel ? p1_req_we    : p0_req_we;
    w_addr    = w_sel ? p1_req_addr  : p0_req_addr;
    w_wdata   = w_sel ? p1_req_wdata : p0_req_wdata;
    w_wstrb   = w_sel ? p1_req_wstrb : p0_req_wstrb;
    w_full    = (w_wstrb == 4'hF);
    w_partial = (w_wstrb != 4'hF) && (w_wstrb != 4'h0);
  end

  // Per-lane merge of new store bytes over the current memory word.
  always_comb begin
    w_merge = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (w_wstrb[i]) begin
        w_merge[8*i +: 8] = w_wdata[8*i +: 8];
      end
    end
  end

  // Memory-side drive: RMW write-back takes priority, idle outputs are zero.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n && (r_state == RMW_WR)) begin
      mem_write = 1'b1;
      mem_addr  = r_rmw_addr;
      mem_wdata = r_merge;
    end else if (w_any_gnt) begin
      mem_addr = w_addr;
      if (!w_we || w_partial) begin
        mem_read = 1'b1;
      end else if (w_full) begin
        mem_write = 1'b1;
        mem_wdata = w_wdata;
      end
    end
  end

  assign p0_req_ready = w_gnt0;
  assign p1_req_ready = w_gnt1;
  assign p0_rsp_valid = r_p0_rsp_valid;
  assign p1_rsp_valid = r_p1_rsp_valid;
  assign p0_rsp_rdata = r_p0_rsp_rdata;
  assign p1_rsp_rdata = r_p1_rsp_rdata;

  // FSM, arbitration history, RMW context and registered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_merge        <= '0;
      r_rmw_addr     <= '0;
      r_rmw_port     <= 1'b0;
      r_p0_rsp_valid <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      r_p0_rsp_rdata <= '0;
      r_p1_rsp_rdata <= '0;
    end else begin
      r_p0_rsp_valid <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      if (r_state == RMW_WR) begin
        r_state <= IDLE;
        if (r_rmw_port) r_p1_rsp_valid <= 1'b1;
        else            r_p0_rsp_valid <= 1'b1;
      end else if (w_any_gnt) begin
        r_last_grant <= w_sel;
        if (w_we && w_partial) begin
          r_state    <= RMW_WR;
          r_merge    <= w_merge;
          r_rmw_addr <= w_addr;
          r_rmw_port <= w_sel;
        end else begin
          if (w_sel) r_p1_rsp_valid <= 1'b1;
          else       r_p0_rsp_valid <= 1'b1;
          if (!w_we) begin
            if (w_sel) r_p1_rsp_rdata <= mem_rdata;
            else       r_p0_rsp_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Directed bench for dmem_arbiter with a behavioural word memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic [3:0]  p0_req_wstrb;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic [3:0]  p1_req_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [256];
  int          n_vec;
  int          n_err;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k0;
    int k1;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    #0;
    mem[4]  <= 32'hDEADBEEF;   // 0x10
    mem[16] <= 32'hAABBCCDD;   // 0x40
    mem[17] <= 32'h55667788;   // 0x44
    mem[33] <= 32'h12345678;   // 0x84
    for (int k = 0; k < 4; k++) begin
      mem[64 + k]  <= 32'hA000_0000 + k;   // 0x100 + 4k
      mem[128 + k] <= 32'hB000_0000 + k;   // 0x200 + 4k
    end
    rst_n = 1'b0;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h10; p0_req_wdata = 0; p0_req_wstrb = 0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h10; p1_req_wdata = 0; p1_req_wstrb = 0;

    // Reset state: outputs quiet even with requests pending.
    #2;
    chk("rst_p0_ready", {31'b0, p0_req_ready}, 32'd0);
    chk("rst_p1_ready", {31'b0, p1_req_ready}, 32'd0);
    chk("rst_mem_rw",   {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_rsp_valid", {30'b0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    chk("rst_p0_rdata", p0_rsp_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rsp_rdata, 32'd0);
    tick();
    tick();

    // 1: single load from port 0.
    rst_n = 1'b1;
    p1_req_valid = 1'b0;
    #1;
    chk("t1_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    chk("t1_mem_read", {31'b0, mem_read}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    chk("t1_p0_rsp_valid", {31'b0, p0_rsp_valid}, 32'd1);
    chk("t1_p0_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    chk("t1_p1_rsp_valid", {31'b0, p1_rsp_valid}, 32'd0);

    // 2: both ports contend; fresh reset so port 0 wins the first tie.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 8; c++) begin
      p0_req_valid = (k0 < 4); p0_req_addr = 32'h100 + 4 * k0;
      p1_req_valid = (k1 < 4); p1_req_addr = 32'h200 + 4 * k1;
      #1;
      chk("t2_p0_ready", {31'b0, p0_req_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_p1_ready", {31'b0, p1_req_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      if (c % 2 == 0) begin
        chk("t2_p0_rsp", {p0_rsp_valid, p1_rsp_valid, 30'b0}, {2'b10, 30'b0});
        chk("t2_p0_rdata", p0_rsp_rdata, 32'hA000_0000 + k0);
        k0++;
      end else begin
        chk("t2_p1_rsp", {p0_rsp_valid, p1_rsp_valid, 30'b0}, {2'b01, 30'b0});
        chk("t2_p1_rdata", p1_rsp_rdata, 32'hB000_0000 + k1);
        k1++;
      end
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    tick();

    // 3: partial store from port 1, port 0 blocked during the write-back.
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 32'h40;
    p1_req_wdata = 32'h11223344; p1_req_wstrb = 4'b0101;
    #1;
    chk("t3_p1_ready", {31'b0, p1_req_ready}, 32'd1);
    chk("t3_c0_rw", {30'b0, mem_read, mem_write}, 32'd2);
    tick();
    p1_req_valid = 1'b0;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 32'h44;
    #1;
    chk("t3_c1_p0_ready", {31'b0, p0_req_ready}, 32'd0);
    chk("t3_c1_write", {31'b0, mem_write}, 32'd1);
    chk("t3_c1_addr", mem_addr, 32'h40);
    chk("t3_c1_wdata", mem_wdata, 32'hAA22CC44);
    chk("t3_c1_no_ack", {31'b0, p1_rsp_valid}, 32'd0);
    tick();
    chk("t3_c2_ack", {31'b0, p1_rsp_valid}, 32'd1);
    chk("t3_c2_mem", mem[16], 32'hAA22CC44);
    chk("t3_c2_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    chk("t3_p0_rdata", p0_rsp_rdata, 32'h55667788);
    chk("t3_p1_rdata_held", p1_rsp_rdata, 32'hB000_0003);

    // 4: full-word store then load of the same word.
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h80;
    p0_req_wdata = 32'hCAFEF00D; p0_req_wstrb = 4'hF;
    #1;
    chk("t4_store_rw", {30'b0, mem_read, mem_write}, 32'd1);
    tick();
    chk("t4_ack", {31'b0, p0_rsp_valid}, 32'd1);
    p0_req_we = 1'b0;
    #1;
    chk("t4_load_no_rmw", {30'b0, mem_read, mem_write}, 32'd2);
    chk("t4_load_ready", {31'b0, p0_req_ready}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    chk("t4_rdata", p0_rsp_rdata, 32'hCAFEF00D);

    // 5: empty-strobe store touches nothing.
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 32'h84;
    p1_req_wdata = 32'hFFFFFFFF; p1_req_wstrb = 4'h0;
    #1;
    chk("t5_ready", {31'b0, p1_req_ready}, 32'd1);
    chk("t5_rw", {30'b0, mem_read, mem_write}, 32'd0);
    tick();
    p1_req_valid = 1'b0;
    chk("t5_ack", {31'b0, p1_rsp_valid}, 32'd1);
    chk("t5_rw_after", {30'b0, mem_read, mem_write}, 32'd0);
    chk("t5_mem", mem[33], 32'h12345678);

    // 6: reset during the write-back cycle.
    tick();
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 32'h88;
    p0_req_wdata = 32'hFFFFFFFF; p0_req_wstrb = 4'b0001;
    #1;
    chk("t6_ready", {31'b0, p0_req_ready}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    chk("t6_rmw_write", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_write_dropped", {30'b0, mem_read, mem_write}, 32'd0);
    tick();
    chk("t6_no_ack", {30'b0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
    chk("t6_mem", mem[34], 32'h0);
    rst_n = 1'b1;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 32'h88;
    #1;
    chk("t6_post_ready", {31'b0, p1_req_ready}, 32'd1);
    tick();
    p1_req_valid = 1'b0;
    chk("t6_post_rsp", {30'b0, p0_rsp_valid, p1_rsp_valid}, 32'd1);
    chk("t6_post_rdata", p1_rsp_rdata, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
